// File: rtl/wb_core_arbiter.sv
// Round-robin Wishbone B3 arbiter merging NUM_MASTERS flattened masters onto one master port.
// Optional stall watchdog: define WB_ARB_TIMEOUT_EN to force an err after TIMEOUT_CYCLES stalls.
module wb_core_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic [AW*NUM_MASTERS-1:0] wbm_adr_i,
    input  logic [DW*NUM_MASTERS-1:0] wbm_dat_i,
    input  logic [4*NUM_MASTERS-1:0]  wbm_sel_i,
    input  logic [NUM_MASTERS-1:0]    wbm_we_i,
    input  logic [NUM_MASTERS-1:0]    wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]    wbm_stb_i,
    input  logic [3*NUM_MASTERS-1:0]  wbm_cti_i,
    input  logic [2*NUM_MASTERS-1:0]  wbm_bte_i,
    output logic [DW*NUM_MASTERS-1:0] wbm_dat_o,
    output logic [NUM_MASTERS-1:0]    wbm_ack_o,
    output logic [NUM_MASTERS-1:0]    wbm_err_o,
    output logic [NUM_MASTERS-1:0]    wbm_rty_o,
    output logic [AW-1:0]             wbs_adr_o,
    output logic [DW-1:0]             wbs_dat_o,
    output logic [3:0]                wbs_sel_o,
    output logic                      wbs_we_o,
    output logic                      wbs_cyc_o,
    output logic                      wbs_stb_o,
    output logic [2:0]                wbs_cti_o,
    output logic [1:0]                wbs_bte_o,
    input  logic [DW-1:0]             wbs_dat_i,
    input  logic                      wbs_ack_i,
    input  logic                      wbs_err_i,
    input  logic                      wbs_rty_i,
    output logic [NUM_MASTERS-1:0]    grant_o
);
    localparam int OW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    if (NUM_MASTERS < 1 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("wb_core_arbiter: NUM_MASTERS must be 1..8 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic {IDLE, BUSY} state_e;

    state_e                 state_q, state_d;
    logic [OW-1:0]          owner_q, owner_d;
    logic [OW-1:0]          last_q, last_d;
    logic [OW-1:0]          pick;
    logic [OW:0]            start, sel;
    logic [2*NUM_MASTERS-1:0] dbl;
    logic                   any_req;
    logic                   busy, own_cyc, own_stb, to_hit;

    assign busy    = (state_q == BUSY);
    assign own_cyc = wbm_cyc_i[owner_q];
    assign own_stb = wbm_stb_i[owner_q];

    // Rotate requests so bit 0 is the master right after the last owner; lowest set bit wins.
    always_comb begin
        start = {1'b0, last_q} + (OW+1)'(1);
        if (start >= (OW+1)'(NUM_MASTERS))
            start = '0;
        dbl     = {wbm_cyc_i, wbm_cyc_i} >> start;
        any_req = 1'b0;
        sel     = start;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (dbl[i]) begin
                any_req = 1'b1;
                sel     = start + (OW+1)'(i);
            end
        end
        if (sel >= (OW+1)'(NUM_MASTERS))
            sel = sel - (OW+1)'(NUM_MASTERS);
        pick = sel[OW-1:0];
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = BUSY;
                    owner_d = pick;
                end
            end
            BUSY: begin
                if (!own_cyc) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= OW'(NUM_MASTERS - 1);
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          resp, stall;

    assign resp  = wbs_ack_i | wbs_err_i | wbs_rty_i;
    assign stall = busy & own_cyc & own_stb & ~resp;

    // Holding the counter at zero while idle gives the clear-on-grant behaviour.
    always_comb begin
        to_hit = stall && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
        cnt_d  = cnt_q;
        if (!busy || resp || to_hit)
            cnt_d = '0;
        else if (stall)
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
`else
    assign to_hit = 1'b0;
`endif

    assign wbm_dat_o = {NUM_MASTERS{wbs_dat_i}};

    always_comb begin
        wbs_adr_o = wbm_adr_i[owner_q*AW +: AW];
        wbs_dat_o = wbm_dat_i[owner_q*DW +: DW];
        wbs_sel_o = wbm_sel_i[owner_q*4 +: 4];
        wbs_cti_o = wbm_cti_i[owner_q*3 +: 3];
        wbs_bte_o = wbm_bte_i[owner_q*2 +: 2];
        wbs_we_o  = wbm_we_i[owner_q];
        wbs_cyc_o = busy & own_cyc;
        wbs_stb_o = busy & own_cyc & own_stb;
        grant_o   = '0;
        wbm_ack_o = '0;
        wbm_err_o = '0;
        wbm_rty_o = '0;
        if (busy) begin
            grant_o[owner_q]   = 1'b1;
            wbm_ack_o[owner_q] = wbs_ack_i & ~to_hit;
            wbm_err_o[owner_q] = wbs_err_i | to_hit;
            wbm_rty_o[owner_q] = wbs_rty_i;
        end
    end

endmodule

// File: tb/tb_wb_core_arbiter.sv
// Self-checking bench for wb_core_arbiter: directed scenarios plus a randomized run
// against a rotating-priority reference model. Honors WB_ARB_TIMEOUT_EN.
module tb_wb_core_arbiter;
    localparam int NM = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [AW*NM-1:0]  m_adr;
    logic [DW*NM-1:0]  m_dat;
    logic [4*NM-1:0]   m_sel;
    logic [NM-1:0]     m_we, m_cyc, m_stb;
    logic [3*NM-1:0]   m_cti;
    logic [2*NM-1:0]   m_bte;
    logic [DW*NM-1:0]  m_dat_o;
    logic [NM-1:0]     m_ack, m_err, m_rty, grant;
    logic [AW-1:0]     s_adr;
    logic [DW-1:0]     s_dat_o, s_dat_i;
    logic [3:0]        s_sel;
    logic              s_we, s_cyc, s_stb, s_ack, s_err, s_rty;
    logic [2:0]        s_cti;
    logic [1:0]        s_bte;

    int checks = 0;
    int errors = 0;

    wb_core_arbiter #(.NUM_MASTERS(NM), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_sel_i(m_sel), .wbm_we_i(m_we),
        .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb), .wbm_cti_i(m_cti), .wbm_bte_i(m_bte),
        .wbm_dat_o(m_dat_o), .wbm_ack_o(m_ack), .wbm_err_o(m_err), .wbm_rty_o(m_rty),
        .wbs_adr_o(s_adr), .wbs_dat_o(s_dat_o), .wbs_sel_o(s_sel), .wbs_we_o(s_we),
        .wbs_cyc_o(s_cyc), .wbs_stb_o(s_stb), .wbs_cti_o(s_cti), .wbs_bte_o(s_bte),
        .wbs_dat_i(s_dat_i), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
        .grant_o(grant)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0; m_cyc = '0; m_stb = '0;
        m_cti = '0; m_bte = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_dat_i = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drive_m(input int k, input logic cyc, input logic stb, input logic we,
                           input logic [AW-1:0] adr, input logic [DW-1:0] dat, input logic [2:0] cti);
        m_cyc[k] = cyc;
        m_stb[k] = stb;
        m_we[k]  = we;
        m_adr[k*AW +: AW] = adr;
        m_dat[k*DW +: DW] = dat;
        m_cti[k*3 +: 3]   = cti;
        m_sel[k*4 +: 4]   = 4'hf;
    endtask

    task automatic test_reset();
        rst = 1'b1; m_cyc = '1; m_stb = '1; s_ack = 1'b1; s_err = 1'b1; s_rty = 1'b1;
        tick();
        tick();
        #1;
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant got %b want 00", grant); end
        checks++; if ({s_cyc, s_stb} !== 2'b00) begin errors++; $display("FAIL rst_cyc_stb got %b want 00", {s_cyc, s_stb}); end
        checks++; if ({m_ack, m_err, m_rty} !== 6'b0) begin errors++; $display("FAIL rst_resp got %b want 000000", {m_ack, m_err, m_rty}); end
    endtask

    task automatic test_single();
        apply_reset();
        drive_m(0, 1'b1, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 3'b000);
        #1;
        checks++; if ({s_cyc, grant} !== 3'b000) begin errors++; $display("FAIL single_latency got %b want 000", {s_cyc, grant}); end
        tick(); #1;
        checks++; if ({s_cyc, grant} !== 3'b101) begin errors++; $display("FAIL single_grant got %b want 101", {s_cyc, grant}); end
        checks++; if ({s_adr, s_dat_o, s_we} !== {32'h100, 32'hDEADBEEF, 1'b1}) begin errors++; $display("FAIL single_req got %h %h %b want 100 deadbeef 1", s_adr, s_dat_o, s_we); end
        tick(); #1;
        checks++; if (m_ack !== 2'b00) begin errors++; $display("FAIL single_noack got %b want 00", m_ack); end
        tick(); s_ack = 1'b1; s_dat_i = 32'h12345678; #1;
        checks++; if (m_ack !== 2'b01) begin errors++; $display("FAIL single_ack got %b want 01", m_ack); end
        checks++; if (m_dat_o !== {2{32'h12345678}}) begin errors++; $display("FAIL single_rdata got %h want %h", m_dat_o, {2{32'h12345678}}); end
        tick(); s_ack = 1'b0; drive_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000); #1;
        checks++; if ({s_cyc, grant} !== 3'b001) begin errors++; $display("FAIL single_release got %b want 001", {s_cyc, grant}); end
        tick(); #1;
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL single_idle got %b want 00", grant); end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        drive_m(0, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 3'b000);
        drive_m(1, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 3'b000);
        tick(); s_ack = 1'b1; #1;
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL simul_first got %b want 01", grant); end
        checks++; if ({s_adr, m_ack} !== {32'h200, 2'b01}) begin errors++; $display("FAIL simul_m0 got %h %b want 200 01", s_adr, m_ack); end
        tick(); s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0; #1;
        checks++; if ({s_cyc, grant} !== 3'b001) begin errors++; $display("FAIL simul_release got %b want 001", {s_cyc, grant}); end
        tick(); #1;
        checks++; if ({s_cyc, grant} !== 3'b000) begin errors++; $display("FAIL simul_gap got %b want 000", {s_cyc, grant}); end
        tick(); s_rty = 1'b1; #1;
        checks++; if ({grant, s_adr} !== {2'b10, 32'h300}) begin errors++; $display("FAIL simul_second got %b %h want 10 300", grant, s_adr); end
        checks++; if (m_rty !== 2'b10) begin errors++; $display("FAIL simul_rty got %b want 10", m_rty); end
        tick(); s_rty = 1'b0; s_ack = 1'b1; #1;
        checks++; if (m_ack !== 2'b10) begin errors++; $display("FAIL simul_ack got %b want 10", m_ack); end
        tick(); s_ack = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
        tick();
    endtask

    task automatic test_burst();
        drive_m(1, 1'b1, 1'b1, 1'b0, 32'h1000, 32'h0, 3'b010);
        tick();
        for (int b = 0; b < 8; b++) begin
            if (b == 4) begin
                m_stb[1] = 1'b0; s_ack = 1'b0; #1;
                checks++; if (grant !== 2'b10) begin errors++; $display("FAIL burst_gap got %b want 10", grant); end
                tick();
            end
            drive_m(1, 1'b1, 1'b1, 1'b0, 32'h1000 + 32'(4 * b), 32'h0, (b == 7) ? 3'b111 : 3'b010);
            if (b == 2) drive_m(0, 1'b1, 1'b1, 1'b0, 32'h2000, 32'h0, 3'b000);
            s_ack = 1'b1; #1;
            checks++; if ({grant, m_ack} !== 4'b1010) begin errors++; $display("FAIL burst_beat%0d got %b want 1010", b, {grant, m_ack}); end
            if (b == 7) begin
                checks++; if (s_cti !== 3'b111) begin errors++; $display("FAIL burst_cti got %b want 111", s_cti); end
            end
            tick();
        end
        s_ack = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0; #1;
        checks++; if ({grant, m_ack} !== 4'b1000) begin errors++; $display("FAIL burst_release got %b want 1000", {grant, m_ack}); end
        tick(); #1;
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL burst_idle got %b want 00", grant); end
        tick(); s_ack = 1'b1; #1;
        checks++; if ({grant, s_adr, m_ack} !== {2'b01, 32'h2000, 2'b01}) begin errors++; $display("FAIL burst_waiter got %b %h %b want 01 2000 01", grant, s_adr, m_ack); end
        tick(); s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        tick();
    endtask

    task automatic test_alternate();
        apply_reset();
        drive_m(0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 3'b000);
        drive_m(1, 1'b1, 1'b1, 1'b0, 32'h80, 32'h0, 3'b000);
        for (int t = 0; t < 10; t++) begin
            int o;
            int n;
            logic [NM-1:0] exp_g;
            o = t % 2;
            n = 0;
            exp_g = NM'(1) << o;
            while (grant == '0 && n < 8) begin tick(); n++; end
            s_ack = 1'b1; #1;
            checks++; if (grant !== exp_g) begin errors++; $display("FAIL alt_grant%0d got %b want %b", t, grant, exp_g); end
            checks++; if (m_ack !== exp_g) begin errors++; $display("FAIL alt_ack%0d got %b want %b", t, m_ack, exp_g); end
            tick(); s_ack = 1'b0; m_cyc[o] = 1'b0; m_stb[o] = 1'b0;
            tick(); #1;
            checks++; if (grant !== 2'b00) begin errors++; $display("FAIL alt_gap%0d got %b want 00", t, grant); end
            m_cyc[o] = 1'b1; m_stb[o] = 1'b1;
        end
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        drive_m(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 3'b000);
        tick(); s_ack = 1'b1;
        tick(); s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        drive_m(1, 1'b1, 1'b1, 1'b1, 32'h3000, 32'h55, 3'b010);
        tick();
        tick(); #1;
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL rstb_grant got %b want 10", grant); end
        s_ack = 1'b1;
        tick(); tick();
        rst = 1'b1;
        tick(); rst = 1'b0;
        drive_m(0, 1'b1, 1'b1, 1'b0, 32'h4000, 32'h0, 3'b000); #1;
        checks++; if ({s_cyc, s_stb, grant} !== 4'b0000) begin errors++; $display("FAIL rstb_idle got %b want 0000", {s_cyc, s_stb, grant}); end
        checks++; if (m_ack !== 2'b00) begin errors++; $display("FAIL rstb_drop got %b want 00", m_ack); end
        s_ack = 1'b0;
        tick(); #1;
        checks++; if ({grant, s_adr} !== {2'b01, 32'h4000}) begin errors++; $display("FAIL rstb_fresh got %b %h want 01 4000", grant, s_adr); end
    endtask

    task automatic test_timeout();
        int early;
        int nerr;
        early = 0;
        nerr = 0;
        apply_reset();
        drive_m(0, 1'b1, 1'b1, 1'b0, 32'h500, 32'h0, 3'b000);
        tick();
`ifdef WB_ARB_TIMEOUT_EN
        for (int c = 1; c <= TO - 1; c++) begin
            #1; if (m_err !== 2'b00) early++;
            tick();
        end
        #1;
        checks++; if (early !== 0) begin errors++; $display("FAIL to_early got %0d want 0", early); end
        checks++; if ({m_err, m_ack} !== 4'b0100) begin errors++; $display("FAIL to_pulse got %b want 0100", {m_err, m_ack}); end
        tick(); #1;
        checks++; if ({m_err, grant} !== 4'b0001) begin errors++; $display("FAIL to_after got %b want 0001", {m_err, grant}); end
`else
        for (int c = 0; c < 1000; c++) begin
            #1; if (m_err !== 2'b00) nerr++;
            tick();
        end
        checks++; if (nerr !== 0) begin errors++; $display("FAIL noto_err got %0d want 0", nerr); end
        checks++; if ({grant, s_cyc} !== 3'b011) begin errors++; $display("FAIL noto_hang got %b want 011", {grant, s_cyc}); end
`endif
    endtask

    task automatic test_random();
        int owner, last, streak, resp;
        int beats [NM];
        int gap [NM];
        logic [AW-1:0] adr [NM];
        logic [NM-1:0] eg, ea, ee;
        logic busy, ecyc;
        apply_reset();
        owner = -1; last = NM - 1; streak = 0;
        for (int k = 0; k < NM; k++) begin beats[k] = 0; gap[k] = $urandom_range(0, 2); adr[k] = '0; end
        for (int cy = 0; cy < 400; cy++) begin
            for (int k = 0; k < NM; k++) begin
                if (beats[k] == 0) begin
                    if (gap[k] > 0) gap[k]--;
                    else begin beats[k] = $urandom_range(1, 4); adr[k] = $urandom & 32'hFFFF_FFFC; end
                end
                drive_m(k, beats[k] > 0, (beats[k] > 0) && ($urandom_range(0, 3) != 0), 1'($urandom),
                        adr[k], $urandom, (beats[k] > 1) ? 3'b010 : 3'b111);
            end
            busy = (owner >= 0);
            eg = busy ? NM'(1) << owner : '0;
            ecyc = busy ? m_cyc[owner] : 1'b0;
            s_dat_i = $urandom;
            s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
            if (!busy) s_ack = 1'($urandom);
            else if (m_stb[owner]) begin
                resp = $urandom_range(0, 7);
                if (streak >= 8) resp = 4;
                s_ack = (resp >= 4 && resp <= 6);
                s_err = (resp == 7);
                if (s_ack || s_err) streak = 0; else streak++;
            end
            ea = (busy && s_ack) ? eg : '0;
            ee = (busy && s_err) ? eg : '0;
            #1;
            checks++; if (grant !== eg) begin errors++; $display("FAIL rnd_grant c%0d got %b want %b", cy, grant, eg); end
            checks++; if (s_cyc !== ecyc) begin errors++; $display("FAIL rnd_cyc c%0d got %b want %b", cy, s_cyc, ecyc); end
            checks++; if ({m_ack, m_err} !== {ea, ee}) begin errors++; $display("FAIL rnd_resp c%0d got %b want %b", cy, {m_ack, m_err}, {ea, ee}); end
            checks++; if (m_dat_o !== {NM{s_dat_i}}) begin errors++; $display("FAIL rnd_rdata c%0d got %h want %h", cy, m_dat_o, {NM{s_dat_i}}); end
            if (busy) begin
                checks++; if (s_adr !== adr[owner]) begin errors++; $display("FAIL rnd_adr c%0d got %h want %h", cy, s_adr, adr[owner]); end
                if (m_stb[owner] && (s_ack || s_err)) begin
                    beats[owner]--;
                    if (beats[owner] == 0) gap[owner] = $urandom_range(1, 3);
                end
                if (!m_cyc[owner]) begin last = owner; owner = -1; end
            end else begin
                for (int i = 1; i <= NM; i++) begin
                    int k;
                    k = (last + i) % NM;
                    if (owner < 0 && m_cyc[k]) owner = k;
                end
                if (owner >= 0) streak = 0;
            end
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "bench did not finish");
    end

    initial begin
        rst = 1'b1;
        m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0; m_cyc = '0; m_stb = '0;
        m_cti = '0; m_bte = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_dat_i = '0;
        test_reset();
        test_single();
        test_simultaneous();
        test_burst();
        test_alternate();
        test_reset_mid_burst();
        test_timeout();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
